// File: rtl/sram_clr.sv
// Single-port SRAM with a self-clearing sweep. After reset, or on a clr_i
// request, every word is overwritten with CLR_VALUE, one word per cycle.
// Accesses are held off (gnt_o low) until the sweep completes.
// Reads return data 1 (OUT_REGS=0) or 2 (OUT_REGS=1) cycles after the grant.
module sram_clr #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    NUM_WORDS  = 1024,
  parameter int                    OUT_REGS   = 0,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0,
  localparam int                   AW         = $clog2(NUM_WORDS),
  localparam int                   BW         = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BW-1:0]         be_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  busy_o
);

  // Number of registered stages between the grant and rdata_o.
  localparam int STAGES = (OUT_REGS != 0) ? 2 : 1;

  typedef enum logic {CLEAR, READY} state_e;

  state_e                            state_q, state_d;
  logic [AW-1:0]                     clr_cnt_q, clr_cnt_d;

  // Storage is deliberately not reset; the sweep initialises it.
  logic [DATA_WIDTH-1:0]             mem [NUM_WORDS];

  logic                              in_range;
  logic                              rd_gnt, wr_gnt;
  logic                              mem_we;
  logic [AW-1:0]                     mem_waddr;
  logic [DATA_WIDTH-1:0]             mem_wdata, mem_wmask, rd_word;

  logic [STAGES:1]                   vld_pipe_q, vld_pipe_d;
  logic [STAGES:1][DATA_WIDTH-1:0]   dat_pipe_q, dat_pipe_d;

  assign busy_o   = (state_q == CLEAR);
  assign gnt_o    = req_i & (state_q == READY) & ~clr_i;
  assign in_range = 32'(addr_i) < NUM_WORDS;
  assign rd_gnt   = gnt_o & ~we_i;
  assign wr_gnt   = gnt_o & we_i;

  // Sweep sequencing: clr_i always restarts the sweep from word 0.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_i) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == AW'(NUM_WORDS - 1)) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      READY: begin
        if (clr_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

  // FSM state and clear counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Write port: sweep writes win; user writes are byte-masked and dropped
  // when the address lies beyond the last word.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_i;
    mem_wdata = wdata_i;
    mem_wmask = '0;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = CLR_VALUE;
      mem_wmask = '1;
    end else if (wr_gnt && in_range) begin
      mem_we = 1'b1;
      for (int i = 0; i < DATA_WIDTH; i++) mem_wmask[i] = be_i[i/8];
    end
  end

  // Storage array update (no reset).
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  // Out-of-range reads still complete, returning zero.
  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem[addr_i];
  end

  // Read pipeline: data stages load only with a valid so rdata_o holds its
  // last read value between results.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[1] = rd_gnt;
    dat_pipe_d[1] = rd_gnt ? rd_word : dat_pipe_q[1];
    for (int s = 2; s <= STAGES; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      dat_pipe_d[s] = vld_pipe_q[s-1] ? dat_pipe_q[s-1] : dat_pipe_q[s];
    end
  end

  // Read pipeline registers; reset drops any in-flight read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign rdata_o  = dat_pipe_q[STAGES];
  assign rvalid_o = vld_pipe_q[STAGES];

endmodule
